mem_ctrl: RTL and testbench
===========================

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter DEPTH, 512, number of 32-bit words in the memory array.
REQ-002 Parameter ADDR_W, 9, address bits used, with DEPTH equal to 2**ADDR_W.
REQ-003 Parameter WAIT_STATES, 1, extra cycles inserted before each access (range 0..15).
REQ-004 Port clk  in  1  system clock, rising-edge active.
REQ-005 Port clr  in  1  reset, asynchronous, active-high.
REQ-006 Port mar_q  in  32  address from MAR; bits [ADDR_W-1:0] index the array.
REQ-007 Port mdr_q  in  32  write data from MDR.
REQ-008 Port read  in  1  read request, sampled in IDLE only.
REQ-009 Port write  in  1  write request, sampled in IDLE only.
REQ-010 Port mdatain  out  32  read data to the MDR input mux, registered.
REQ-011 Port mem_rdy  out  1  one-cycle completion pulse.
REQ-012 Port busy  out  1  high while a transfer is in progress (ACCESS or DONE).
REQ-013 Port err  out  1  address-range error pulse; tied 0 when the feature is compiled out.

Function
REQ-014 The FSM SHALL have three states: IDLE, ACCESS and DONE.
REQ-015 In IDLE, at a rising edge with read or write high, the block SHALL latch address, data and operation, clear the wait counter and enter ACCESS.
REQ-016 When read and write are high together in IDLE, read SHALL win and the write SHALL be discarded.
REQ-017 In ACCESS, the wait counter SHALL increment each edge; at the edge where it equals WAIT_STATES, the access SHALL execute and the FSM SHALL enter DONE.
REQ-018 A write SHALL update mem[addr] with the latched data; a read SHALL load mdatain with mem[addr] at the same edge.
REQ-019 In DONE, mem_rdy SHALL be high for exactly one cycle, and the FSM SHALL return to IDLE at the next edge.
REQ-020 Latency SHALL be WAIT_STATES+1 cycles from the request-sampling edge to mem_rdy rising; each transfer SHALL occupy WAIT_STATES+3 cycles back to back.
REQ-021 Requests while busy is high SHALL be ignored; read/write held high through DONE SHALL start a new transfer at the IDLE edge that follows.
REQ-022 mdatain SHALL hold its value until the next successful read completes; writes SHALL NOT change it.
REQ-023 mar_q and mdr_q changes after the sampling edge SHALL NOT affect the transfer in progress.

Reset
REQ-024 While clr is high: state SHALL be IDLE, counter 0, mdatain 0, mem_rdy 0, busy 0 and err 0.
REQ-025 Reset SHALL NOT clear memory contents.
REQ-026 A reset asserted during ACCESS SHALL abort the transfer, leaving the memory word unmodified and producing no mem_rdy pulse.

Configuration
REQ-027 Macro MEM_CTRL_RANGE_CHECK_EN defined: latched mar_q[31:ADDR_W] nonzero SHALL suppress the memory access, leave mdatain unchanged, and pulse err together with mem_rdy.
REQ-028 Macro undefined: upper address bits SHALL be ignored (address wraps modulo DEPTH) and err SHALL be constant 0.

Structure
REQ-029 Package mem_ctrl_pkg SHALL hold the state typedef (IDLE/ACCESS/DONE) and the default DEPTH, ADDR_W and WAIT_STATES constants.
REQ-030 The array SHALL be a sub-module mem_ram: single-port, synchronous write, synchronous read, DEPTH x 32.

Verification
REQ-031 WAIT_STATES=1: write mdr_q=32'hDEADBEEF to mar_q=5, then read addr 5 -> mem_rdy 2 cycles after each request, mdatain=32'hDEADBEEF.
REQ-032 read and write both high, addr 7 preloaded with 32'h12345678, mdr_q=0 -> mdatain=32'h12345678 and mem[7] unchanged.
REQ-033 Write to addr 3 with clr pulsed during ACCESS -> no mem_rdy, mem[3] keeps its old value, all outputs 0.
REQ-034 Read held high for 10 cycles, WAIT_STATES=1 -> mem_rdy pulses every 4 cycles, busy low only one cycle between pulses.
REQ-035 MEM_CTRL_RANGE_CHECK_EN defined, read mar_q=32'h00000200 -> err and mem_rdy pulse together and mdatain keeps its prior value; macro undefined -> reads addr 0 and err stays 0.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl shared types and default sizing.
// Holds the controller state encoding and parameter defaults.
package mem_ctrl_pkg;

  localparam int DEF_DEPTH       = 512;
  localparam int DEF_ADDR_W      = 9;
  localparam int DEF_WAIT_STATES = 1;
  localparam int DATA_W          = 32;
  localparam int CNT_W           = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/mem_ctrl_ram.sv
// mem_ram: single-port DEPTH x 32 array, synchronous write and read.
// Read register resets to zero; array contents survive reset.
module mem_ram
  import mem_ctrl_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;

  // array write port, no reset so contents persist
  always_ff @(posedge clk) begin
    if (en && we) r_mem[addr] <= wdata;
  end

  // read register, only loaded by a read access
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             r_rdata <= '0;
    else if (en && !we)  r_rdata <= r_mem[addr];
  end

  assign rdata = r_rdata;

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: wait-state memory controller (IDLE -> ACCESS -> DONE).
// Define MEM_CTRL_RANGE_CHECK_EN to flag out-of-range addresses on err.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int DEPTH       = DEF_DEPTH,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int WAIT_STATES = DEF_WAIT_STATES
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] mar_q,
  input  logic [31:0] mdr_q,
  input  logic        read,
  input  logic        write,
  output logic [31:0] mdatain,
  output logic        mem_rdy,
  output logic        busy,
  output logic        err
);

  localparam logic [CNT_W-1:0] WS = CNT_W'(WAIT_STATES);

  state_t              r_state;
  state_t              w_nstate;
  logic [CNT_W-1:0]    r_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_data;
  logic                r_wr;
  logic                w_req;
  logic                w_exec;
  logic                w_en;

  assign w_req  = read | write;
  assign w_exec = (r_state == ACCESS) && (r_cnt == WS);

  // state register
  always_ff @(posedge clk or posedge clr) begin
    if (clr) r_state <= IDLE;
    else     r_state <= w_nstate;
  end

  // next state and status outputs
  always_comb begin
    w_nstate = r_state;
    mem_rdy  = 1'b0;
    busy     = 1'b0;
    unique case (r_state)
      IDLE:    if (w_req) w_nstate = ACCESS;
      ACCESS: begin
        busy = 1'b1;
        if (w_exec) w_nstate = DONE;
      end
      DONE: begin
        busy     = 1'b1;
        mem_rdy  = 1'b1;
        w_nstate = IDLE;
      end
      default: w_nstate = IDLE;
    endcase
  end

  // request capture and wait counter; read wins a tie
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_cnt  <= '0;
      r_addr <= '0;
      r_data <= '0;
      r_wr   <= 1'b0;
    end else if (r_state == IDLE && w_req) begin
      r_cnt  <= '0;
      r_addr <= mar_q[ADDR_W-1:0];
      r_data <= mdr_q;
      r_wr   <= write & ~read;
    end else if (r_state == ACCESS) begin
      r_cnt  <= r_cnt + 1'b1;
    end
  end

`ifdef MEM_CTRL_RANGE_CHECK_EN
  logic r_oob;

  // latch whether the upper address bits were nonzero
  always_ff @(posedge clk or posedge clr) begin
    if (clr)                          r_oob <= 1'b0;
    else if (r_state == IDLE && w_req) r_oob <= |mar_q[31:ADDR_W];
  end

  assign w_en = w_exec & ~r_oob;
  assign err  = (r_state == DONE) & r_oob;
`else
  logic w_unused;
  assign w_unused = &{1'b0, mar_q[31:ADDR_W]};
  assign w_en     = w_exec;
  assign err      = 1'b0;
`endif

  mem_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .rst   (clr),
    .en    (w_en),
    .we    (r_wr),
    .addr  (r_addr),
    .wdata (r_data),
    .rdata (mdatain)
  );

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed checks of mem_ctrl with WAIT_STATES=1.
// Honours MEM_CTRL_RANGE_CHECK_EN for the out-of-range read case.
module tb_mem_ctrl;

  logic        clk;
  logic        clr;
  logic [31:0] mar_q;
  logic [31:0] mdr_q;
  logic        read;
  logic        write;
  logic [31:0] mdatain;
  logic        mem_rdy;
  logic        busy;
  logic        err;

  int nvec;
  int nerr;
  int npulse;

  mem_ctrl #(
    .DEPTH       (512),
    .ADDR_W      (9),
    .WAIT_STATES (1)
  ) dut (
    .clk     (clk),
    .clr     (clr),
    .mar_q   (mar_q),
    .mdr_q   (mdr_q),
    .read    (read),
    .write   (write),
    .mdatain (mdatain),
    .mem_rdy (mem_rdy),
    .busy    (busy),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // one transfer; inputs are scrambled after the sampling edge
  task automatic xfer(input logic rd, input logic wr,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic exp_err);
    read  = rd;
    write = wr;
    mar_q = a;
    mdr_q = d;
    step();
    read  = 1'b0;
    write = 1'b0;
    mar_q = 32'h0000_01FF;
    mdr_q = 32'h5555_AAAA;
    chk("x_busy0", {31'd0, busy}, 32'd1);
    chk("x_rdy0", {31'd0, mem_rdy}, 32'd0);
    step();
    chk("x_rdy1", {31'd0, mem_rdy}, 32'd0);
    step();
    chk("x_rdy2", {31'd0, mem_rdy}, 32'd1);
    chk("x_err2", {31'd0, err}, {31'd0, exp_err});
    step();
    chk("x_rdy3", {31'd0, mem_rdy}, 32'd0);
    chk("x_busy3", {31'd0, busy}, 32'd0);
    chk("x_err3", {31'd0, err}, 32'd0);
  endtask

  initial begin
    nvec  = 0;
    nerr  = 0;
    clr   = 1'b1;
    read  = 1'b0;
    write = 1'b0;
    mar_q = '0;
    mdr_q = '0;
    step();
    step();
    chk("rst_mdat", mdatain, 32'd0);
    chk("rst_rdy", {31'd0, mem_rdy}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    clr = 1'b0;
    step();

    xfer(1'b0, 1'b1, 32'd5, 32'hDEAD_BEEF, 1'b0);
    chk("wr_keeps_mdat", mdatain, 32'd0);
    xfer(1'b1, 1'b0, 32'd5, 32'h0, 1'b0);
    chk("rd5", mdatain, 32'hDEAD_BEEF);

    xfer(1'b0, 1'b1, 32'd7, 32'h1234_5678, 1'b0);
    xfer(1'b1, 1'b1, 32'd7, 32'h0, 1'b0);
    chk("tie_rd7", mdatain, 32'h1234_5678);
    xfer(1'b1, 1'b0, 32'd7, 32'h0, 1'b0);
    chk("tie_mem7", mdatain, 32'h1234_5678);

    xfer(1'b0, 1'b1, 32'd3, 32'hA5A5_A5A5, 1'b0);
    write = 1'b1;
    mar_q = 32'd3;
    mdr_q = 32'h1111_1111;
    step();
    write = 1'b0;
    chk("ab_busy", {31'd0, busy}, 32'd1);
    #2 clr = 1'b1;
    #1;
    chk("ab_mdat", mdatain, 32'd0);
    chk("ab_busy0", {31'd0, busy}, 32'd0);
    chk("ab_rdy0", {31'd0, mem_rdy}, 32'd0);
    chk("ab_err0", {31'd0, err}, 32'd0);
    for (int k = 0; k < 2; k++) begin
      step();
      chk("ab_rdy_hold", {31'd0, mem_rdy}, 32'd0);
    end
    clr = 1'b0;
    step();
    chk("ab_idle", {31'd0, busy}, 32'd0);
    xfer(1'b1, 1'b0, 32'd3, 32'h0, 1'b0);
    chk("ab_mem3", mdatain, 32'hA5A5_A5A5);

    read   = 1'b1;
    mar_q  = 32'd5;
    npulse = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (k == 9) read = 1'b0;
      if (mem_rdy) npulse++;
      chk("bb_rdy", {31'd0, mem_rdy}, {31'd0, (k % 4) == 2});
      chk("bb_busy", {31'd0, busy}, {31'd0, (k % 4) != 3});
    end
    chk("bb_npulse", npulse, 32'd3);
    chk("bb_mdat", mdatain, 32'hDEAD_BEEF);

    xfer(1'b0, 1'b1, 32'd0, 32'hCAFE_F00D, 1'b0);
`ifdef MEM_CTRL_RANGE_CHECK_EN
    xfer(1'b1, 1'b0, 32'h0000_0200, 32'h0, 1'b1);
    chk("oob_mdat", mdatain, 32'hDEAD_BEEF);
`else
    xfer(1'b1, 1'b0, 32'h0000_0200, 32'h0, 1'b0);
    chk("wrap_mdat", mdatain, 32'hCAFE_F00D);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
